// File: rtl/log_unit_pipe.sv
// log_unit_pipe: pipelined bitwise logic unit with chaining accumulator and a
// 2-entry (main + skid) output buffer behind a valid/ready handshake.
//
// Optional feature macro: LOG_UNIT_PIPE_FLAGS_EN
//   defined   -> out_zero / out_parity are computed at accept and buffered
//                alongside each result
//   undefined -> no flag storage; out_zero / out_parity tied to 0
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand beat handshake
//   x, y, op, in_acc    operands, op select, use accumulator in place of x
//   out_valid/out_ready result handshake
//   out                 result
//   out_zero            result == 0 (feature-gated)
//   out_parity          XOR-reduce of result (feature-gated)
module log_unit_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       op,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             out_parity
);

  // Buffer entry layout: {parity, zero, data} with flags, data alone without.
`ifdef LOG_UNIT_PIPE_FLAGS_EN
  localparam int unsigned ENT_W = WIDTH + 2;
`else
  localparam int unsigned ENT_W = WIDTH;
`endif

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [ENT_W-1:0] main_q, main_d;
  logic [ENT_W-1:0] skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] r;
  logic [ENT_W-1:0] r_ent;
  logic             accept;
  logic             drain;

  // Operand select and operation
  always_comb begin
    a = in_acc ? acc_q : x;
    r = '0;
    case (op)
      3'b000:  r = a & y;
      3'b001:  r = a | y;
      3'b010:  r = a ^ y;
      3'b011:  r = ~(a | y);
      3'b100:  r = a & ~y;
      3'b101:  r = ~(a & y);
      3'b110:  r = a;
      3'b111:  r = y;
      default: r = '0;
    endcase
  end

  // Pack the result (and flags when built) into a buffer entry
`ifdef LOG_UNIT_PIPE_FLAGS_EN
  assign r_ent = {^r, (r == '0), r};
`else
  assign r_ent = r;
`endif

  // Ready depends only on registered skid occupancy (and reset), never on out_ready
  assign in_ready = !skid_valid_q && !rst;
  assign accept   = in_valid && in_ready;
  assign drain    = main_valid_q && out_ready;

  // Buffer and accumulator next-state
  always_comb begin
    acc_d        = acc_q;
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;

    if (accept) acc_d = r;

    if (drain) begin
      if (skid_valid_q) begin
        // skid full implies no accept this cycle; promote skid into main
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d = r_ent;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_d       = r_ent;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = r_ent;
        skid_valid_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out       = main_q[WIDTH-1:0];

`ifdef LOG_UNIT_PIPE_FLAGS_EN
  assign out_zero   = main_q[WIDTH];
  assign out_parity = main_q[WIDTH+1];
`else
  assign out_zero   = 1'b0;
  assign out_parity = 1'b0;
`endif

endmodule

// File: doc/log_unit_pipe.md
# log_unit_pipe

Parametrised, pipelined bitwise logic unit for the MIPS datapath ALU. It is the successor to the fixed 16-bit AND slice. It performs one of eight bitwise operations on two WIDTH-bit operands and can chain operations through an internal accumulator. A valid/ready handshake with a 2-entry output buffer lets it sit between the register-read stage and the ALU result mux at full throughput under backpressure.

## Interface
- WIDTH, 16, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  unit can accept a beat
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B
- op  input  3  operation select
- in_acc  input  1  use accumulator in place of x
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out  output  WIDTH  result
- out_zero  output  1  result == 0 (see Configuration)
- out_parity  output  1  XOR-reduce of result (see Configuration)

## Operation
- Accept: in_valid && in_ready at a rising clk edge.
- Operand a = in_acc ? acc : x; operand b = y.
- op encoding:
  - 000 AND a&b
  - 001 OR a|b
  - 010 XOR a^b
  - 011 NOR ~(a|b)
  - 100 ANDN a&~b
  - 101 NAND ~(a&b)
  - 110 PASSA a
  - 111 PASSB b
- All operations are pure bitwise, width WIDTH, with no carry or overflow.
- acc (WIDTH bits, internal) loads result r on every accepted beat. A beat with in_acc=0 starts a new chain.
- Output buffer has two entries: main (drives out) and skid.
  - Accepted r goes to main if main is empty or is draining this cycle (out_ready=1); otherwise it goes to skid.
  - When main drains and skid is full, skid moves to main in the same edge.
- in_ready = !skid_valid && !rst. It is a registered-state decode, with no combinational path from out_ready.
- Simultaneous accept and drain with skid empty: main is replaced by the new r, and out_valid stays 1.
- Reset (async, any time): main, skid, and acc all clear. Any in-flight results are discarded.
  - Reset values: out_valid=0, out=0, out_zero=0, out_parity=0.
  - in_ready=0 while rst is high, and 1 from the first cycle after rst deasserts.

## Timing
- Latency 1: a beat accepted at edge N appears on out with out_valid=1 after edge N.
- Throughput is one beat per cycle while out_ready=1.
- Chained beats: a beat with in_acc=1 at edge N+1 sees the acc written at edge N. There is no bubble and no stall.
- Backpressure: with out_ready=0 the unit absorbs at most 2 results. in_ready falls after the edge that fills skid.
  - The first cycle of out_ready=1 drains main, moves skid into main, and raises in_ready the following cycle.
- out, out_zero, and out_parity are stable while out_valid && !out_ready.

## Configuration
- Macro: LOG_UNIT_PIPE_FLAGS_EN.
- Defined: out_zero = (r == 0) and out_parity = ^r are computed at accept. They are stored per buffer entry alongside the data and presented with out.
- Undefined: the flag storage is not built, and out_zero and out_parity are tied to 0. The port list is unchanged.

## Test plan
- Op sweep (WIDTH=16): x=16'hF0F0, y=16'hFF00, ops 000–111 on consecutive cycles with out_ready=1 -> out = F000, FFF0, 0FF0, 000F, 00F0, 0FFF, F0F0, FF00. One result per cycle, each one cycle after accept.
- Chain: beat1 op=001 x=16'h0001 y=16'h0002 in_acc=0; beat2 op=001 in_acc=1 y=16'h0004 (x=16'hFFFF ignored); beat3 op=000 in_acc=1 y=16'h0006 -> out = 0003, 0007, 0006, back-to-back.
- Backpressure: out_ready=0, offer 3 beats -> first two accepted and in_ready=0 with the third held. Raise out_ready -> outputs appear in order with none lost or duplicated. The third beat is accepted one cycle after in_ready returns to 1.
- Flags (macro defined): XOR x=y=16'hA5A5 -> out=0000, out_zero=1, out_parity=0. OR x=16'h0001 y=0 -> out_zero=0, out_parity=1. With the macro undefined, both flags read 0.
- Reset mid-operation: fill both buffer entries, then assert rst asynchronously between edges -> out_valid, out, and the flags go to 0 immediately. After release, in_ready=1 and an in_acc=1 PASSA beat returns 0000 (acc cleared).
- WIDTH=32 build: AND x=32'hDEADBEEF y=32'hFFFF0000 -> out=32'hDEAD0000.
